// File: rtl/s10077_emu_pkg.sv
// Shared types and widths for the S10077 linear image sensor responder model.
package s10077_emu_pkg;

  localparam int PIX_W = 11;
  localparam int VID_W = 12;
  localparam int FRM_W = 8;
  localparam int DLY_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    INTEG,
    DELAY,
    READOUT,
    EOS_ST
  } state_e;

endpackage

// File: rtl/s10077_emu_sync_edge.sv
// Two-flop synchronizer plus delay flop for one asynchronous drive input.
// The edge pulses are registered, and level_o is aligned with them.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  // dly_q holds the synchronized level from the same cycle the edge pulse was computed in.
  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/s10077_emu.sv
// S10077 sensor responder: turns SENSOR_CLK/ST drive into EOC/EOS strobes,
// pixel index, test-pattern video and a completed-frame counter.
module s10077_emu
  import s10077_emu_pkg::*;
#(
  parameter int PIXELS    = 1024,
  parameter int START_DLY = 48
) (
  input  logic             fpgaClk_i,
  input  logic             fpgaRst_ni,
  input  logic             sensorClk_i,
  input  logic             st_i,
  output logic             eoc_o,
  output logic             eos_o,
  output logic [PIX_W-1:0] pixIdx_o,
  output logic [VID_W-1:0] video_o,
  output logic [FRM_W-1:0] frameCnt_o,
  output logic             overrun_o
);

  logic sclkLvl, sclkRise, sclkFall;
  logic stLvl, stRise, stFall;
  logic unusedSigs;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dlyCnt_q, dlyCnt_d;
  logic [PIX_W-1:0]  pixIdx_q, pixIdx_d;
  logic [FRM_W-1:0]  frameCnt_q, frameCnt_d;
  logic [VID_W-1:0]  video_q;
  logic              eoc_q, eoc_d;
  logic              eos_q, eos_d;
  logic              overrun_q;

  sync_edge uSclk (
    .clk_i  (fpgaClk_i),
    .rst_ni (fpgaRst_ni),
    .d_i    (sensorClk_i),
    .level_o(sclkLvl),
    .rise_o (sclkRise),
    .fall_o (sclkFall)
  );

  sync_edge uSt (
    .clk_i  (fpgaClk_i),
    .rst_ni (fpgaRst_ni),
    .d_i    (st_i),
    .level_o(stLvl),
    .rise_o (stRise),
    .fall_o (stFall)
  );

  assign unusedSigs = sclkLvl ^ stFall;

  always_ff @(posedge fpgaClk_i or negedge fpgaRst_ni) begin
    if (!fpgaRst_ni) begin
      state_q    <= IDLE;
      dlyCnt_q   <= '0;
      pixIdx_q   <= '0;
      frameCnt_q <= '0;
      video_q    <= '0;
      eoc_q      <= 1'b0;
      eos_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dlyCnt_q   <= dlyCnt_d;
      pixIdx_q   <= pixIdx_d;
      frameCnt_q <= frameCnt_d;
      video_q    <= VID_W'(pixIdx_d) + VID_W'({frameCnt_d, 4'b0000});
      eoc_q      <= eoc_d;
      eos_q      <= eos_d;
      overrun_q  <= stRise && (state_q != IDLE);
    end
  end

  // All scan progress happens on sensor rises; ST is judged by its level at that rise.
  always_comb begin
    state_d    = state_q;
    dlyCnt_d   = dlyCnt_q;
    pixIdx_d   = pixIdx_q;
    frameCnt_d = frameCnt_q;
    eoc_d      = eoc_q;
    eos_d      = eos_q;

    if (sclkFall) begin
      eoc_d = 1'b0;
    end

    if (sclkRise) begin
      case (state_q)
        IDLE: begin
          if (stLvl) state_d = INTEG;
        end
        INTEG: begin
          if (!stLvl) begin
            state_d  = DELAY;
            dlyCnt_d = DLY_W'(1);
          end
        end
        DELAY: begin
          if (dlyCnt_q == DLY_W'(START_DLY)) begin
            pixIdx_d = '0;
            eoc_d    = 1'b1;
            state_d  = READOUT;
          end else begin
            dlyCnt_d = dlyCnt_q + DLY_W'(1);
          end
        end
        READOUT: begin
          if (pixIdx_q == PIX_W'(PIXELS - 1)) begin
            eoc_d   = 1'b0;
            eos_d   = 1'b1;
            state_d = EOS_ST;
          end else begin
            pixIdx_d = pixIdx_q + PIX_W'(1);
            eoc_d    = 1'b1;
          end
        end
        EOS_ST: begin
          eos_d      = 1'b0;
          frameCnt_d = frameCnt_q + FRM_W'(1);
          state_d    = stLvl ? INTEG : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign eoc_o      = eoc_q;
  assign eos_o      = eos_q;
  assign pixIdx_o   = pixIdx_q;
  assign video_o    = video_q;
  assign frameCnt_o = frameCnt_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_s10077_emu.sv
// Randomized-phase bench for s10077_emu: a scan-schedule model predicts every
// EOC/EOS event by sensor-rise number and is compared against a monitor log.
module tb_s10077_emu;
  import s10077_emu_pkg::*;

  localparam int PIXELS    = 8;
  localparam int START_DLY = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             sclk  = 1'b0;
  logic             st    = 1'b0;
  logic             eoc, eos, overrun;
  logic [PIX_W-1:0] pixIdx;
  logic [VID_W-1:0] video;
  logic [FRM_W-1:0] frameCnt;

  typedef struct {
    int rise;
    int pix;
    int video;
    int lat;
  } pixRec_t;

  pixRec_t expPix[$], obsPix[$];
  int      expEosSet[$], obsEosSet[$];
  int      expEosClr[$], obsEosClr[$];

  int checks = 0;
  int errors = 0;
  int cycCnt = 0;
  int riseNo = 0;
  int riseCycle = 0;
  int phaseMin = 8;
  int phaseMax = 8;
  int overrunSeen = 0;
  int overlapCnt = 0;
  bit eocPrev = 1'b0;
  bit eosPrev = 1'b0;

  bit mArmed, mBusy;
  int mEndRise, mFrame;
  int mOverrunExp = 0;

  s10077_emu #(
    .PIXELS   (PIXELS),
    .START_DLY(START_DLY)
  ) dut (
    .fpgaClk_i  (clk),
    .fpgaRst_ni (rst_n),
    .sensorClk_i(sclk),
    .st_i       (st),
    .eoc_o      (eoc),
    .eos_o      (eos),
    .pixIdx_o   (pixIdx),
    .video_o    (video),
    .frameCnt_o (frameCnt),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt = cycCnt + 1;

  // Log output events, tagged with the sensor rise in progress and the latency in clocks.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (eoc && !eocPrev) obsPix.push_back('{riseNo, int'(pixIdx), int'(video), cycCnt - riseCycle});
      if (eos && !eosPrev) obsEosSet.push_back(riseNo);
      if (!eos && eosPrev) obsEosClr.push_back(riseNo);
      if (eoc && eos) overlapCnt = overlapCnt + 1;
      if (overrun) overrunSeen = overrunSeen + 1;
    end
    eocPrev = eoc;
    eosPrev = eos;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obsV, input logic [31:0] expV);
    checks = checks + 1;
    if (obsV !== expV) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obsV, expV);
    end
  endtask

  task automatic modelReset();
    mArmed = 1'b0;
    mBusy  = 1'b0;
    mFrame = 0;
    expPix.delete();    obsPix.delete();
    expEosSet.delete(); obsEosSet.delete();
    expEosClr.delete(); obsEosClr.delete();
  endtask

  // Scan schedule: once ST is seen low after being seen high, pixel i lands on
  // rise (thatRise + START_DLY + i), EOS on the following rise for one period.
  task automatic modelRise(input logic s);
    int base;
    if (mBusy && riseNo == mEndRise) begin
      mFrame = (mFrame + 1) % 256;
      mBusy  = 1'b0;
      mArmed = s;
    end else if (!mBusy) begin
      if (mArmed && !s) begin
        base     = riseNo + START_DLY;
        mBusy    = 1'b1;
        mArmed   = 1'b0;
        mEndRise = base + PIXELS + 1;
        for (int i = 0; i < PIXELS; i++)
          expPix.push_back('{base + i, i, (i + mFrame * 16) % 4096, 3});
        expEosSet.push_back(base + PIXELS);
        expEosClr.push_back(base + PIXELS + 1);
      end else if (s) begin
        mArmed = 1'b1;
      end
    end
  endtask

  // One SENSOR_CLK period; ST changes only at the sensor fall.
  task automatic applyStimulus(input logic stNext);
    int hi, lo;
    hi = int'($urandom_range(phaseMin, phaseMax));
    lo = int'($urandom_range(phaseMin, phaseMax));
    @(negedge clk);
    riseNo    = riseNo + 1;
    riseCycle = cycCnt + 1;
    modelRise(st);
    sclk = 1'b1;
    repeat (hi) @(negedge clk);
    if (stNext && !st && (mBusy || mArmed)) mOverrunExp = mOverrunExp + 1;
    sclk = 1'b0;
    st   = stNext;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic runScan(input int nHigh);
    applyStimulus(1'b1);
    for (int i = 1; i < nHigh; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int i = 0; i < START_DLY + PIXELS + 3; i++) applyStimulus(1'b0);
  endtask

  task automatic checkScoreboard();
    int n;
    checkOutput("eocCount", obsPix.size(), expPix.size());
    n = (obsPix.size() < expPix.size()) ? obsPix.size() : expPix.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("eocRise",  obsPix[i].rise,  expPix[i].rise);
      checkOutput("pixIdx",   obsPix[i].pix,   expPix[i].pix);
      checkOutput("video",    obsPix[i].video, expPix[i].video);
      checkOutput("eocLat",   obsPix[i].lat,   expPix[i].lat);
    end
    checkOutput("eosCount", obsEosSet.size(), expEosSet.size());
    n = (obsEosSet.size() < expEosSet.size()) ? obsEosSet.size() : expEosSet.size();
    for (int i = 0; i < n; i++) checkOutput("eosSetRise", obsEosSet[i], expEosSet[i]);
    checkOutput("eosClrCount", obsEosClr.size(), expEosClr.size());
    n = (obsEosClr.size() < expEosClr.size()) ? obsEosClr.size() : expEosClr.size();
    for (int i = 0; i < n; i++) checkOutput("eosClrRise", obsEosClr[i], expEosClr[i]);
    expPix.delete();    obsPix.delete();
    expEosSet.delete(); obsEosSet.delete();
    expEosClr.delete(); obsEosClr.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Eoc"},     eoc,      0);
    checkOutput({tag, "Eos"},     eos,      0);
    checkOutput({tag, "Pix"},     pixIdx,   0);
    checkOutput({tag, "Video"},   video,    0);
    checkOutput({tag, "Frame"},   frameCnt, 0);
    checkOutput({tag, "Overrun"}, overrun,  0);
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal divide-by-16 scan with ST high for four periods.
    runScan(4);
    checkScoreboard();
    checkOutput("frameFirst", frameCnt, mFrame);

    phaseMin = 3;
    phaseMax = 10;
    runScan(int'($urandom_range(1, 4)));
    checkScoreboard();
    checkOutput("frameSecond", frameCnt, mFrame);

    // ST pulse during readout: overrun only, scan completes, nothing restarts.
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int k = 1; k <= START_DLY + PIXELS + 6; k++) applyStimulus(k == START_DLY + 3);
    checkScoreboard();
    checkOutput("frameOverrun", frameCnt, mFrame);
    checkOutput("overrunPulses", overrunSeen, mOverrunExp);

    // ST high only at the EOS exit rise must still launch the next scan.
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int k = 1; k <= 2 * (START_DLY + PIXELS + 2) + 1; k++)
      applyStimulus(k == START_DLY + PIXELS + 1);
    checkScoreboard();
    checkOutput("frameBackToBack", frameCnt, mFrame);

    // Asynchronous reset in the middle of pixel 4.
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int k = 1; k <= START_DLY + 5; k++) applyStimulus(1'b0);
    checkOutput("prePixBeforeReset", pixIdx, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    runScan(2);
    checkScoreboard();
    checkOutput("frameAfterReset", frameCnt, mFrame);

    // Fast scans until the frame counter wraps.
    phaseMin = 3;
    phaseMax = 5;
    for (int n = 0; n < 255; n++) begin
      runScan(1);
      checkScoreboard();
    end
    checkOutput("frameWrap", frameCnt, mFrame);
    checkOutput("frameWrapZero", frameCnt, 0);

    checkOutput("eocEosOverlap", overlapCnt, 0);
    checkOutput("overrunTotal", overrunSeen, mOverrunExp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
